// File: rtl/alu_seq_if.sv
// Request/response bundle between the op issuer (master) and the
// multi-byte ALU sequencer (slave).
interface alu_seq_if #(
  parameter int BYTES = 2
);
  localparam int W = 8 * BYTES;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_ci;
  logic         req_bcd;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_c;
  logic         rsp_z;
  logic         rsp_n;
  logic         rsp_v;

  modport master (
    output req_valid, req_op, req_a, req_b, req_ci, req_bcd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n, rsp_v
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_ci, req_bcd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_n, rsp_v
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-byte operation sequencer for the shared 8-bit ALU. One W-bit op is
// accepted per request, fed to the ALU a byte per cycle with carry chained
// through the ALU's registered carry out, and returned with word flags.
module alu_seq #(
  parameter int BYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [3:0] alu_op,
  output logic       alu_right,
  output logic [7:0] alu_ai,
  output logic [7:0] alu_bi,
  output logic       alu_ci,
  output logic       alu_bcd,
  output logic       alu_rdy,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_v
);

  localparam int W  = 8 * BYTES;
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_EOR = 3'd5;
  localparam logic [2:0] OP_ROL = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_reg;
  logic [KW-1:0] k_reg;
  logic [2:0]    op_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          ci_reg;
  logic          bcd_reg;
  logic [7:0]    res_reg [BYTES];
  logic          nz_reg;          // any captured result byte was nonzero
  logic          c_reg;
  logic          z_reg;
  logic          n_reg;
  logic          v_reg;

  logic [7:0]    a_byte [BYTES];
  logic [7:0]    b_byte [BYTES];
  logic [W-1:0]  res_word;

  // Byte views of the latched operands and the assembled result word
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_bytes
      assign a_byte[gi]              = a_reg[gi*8 +: 8];
      assign b_byte[gi]              = b_reg[gi*8 +: 8];
      assign res_word[gi*8 +: 8]     = res_reg[gi];
    end
  endgenerate

  // Op class decode from the latched op
  logic is_ror;
  logic is_rol;
  logic is_logic;
  logic is_arith;
  assign is_ror   = (op_reg == OP_ROR);
  assign is_rol   = (op_reg == OP_ROL);
  assign is_logic = (op_reg == OP_OR) || (op_reg == OP_AND) || (op_reg == OP_EOR);
  assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);

  // Byte being issued this cycle, the slot the previous byte's result goes
  // to, and the slot of the final byte captured in DRAIN. ROR walks MSB first
  // so the shifted-out bit of each byte carries into the next lower byte.
  logic [KW-1:0] issue_idx;
  logic [KW-1:0] prev_idx;
  logic [KW-1:0] last_idx;
  assign issue_idx = is_ror ? (K_LAST - k_reg) : k_reg;
  assign prev_idx  = is_ror ? (issue_idx + KW'(1)) : (k_reg - KW'(1));
  assign last_idx  = is_ror ? '0 : K_LAST;

  // MSB of the finished word: it is the byte landing in DRAIN unless ROR
  // already stored the top byte during ISSUE.
  logic final_msb;
  assign final_msb = (last_idx == K_LAST) ? alu_out[7] : res_reg[BYTES-1][7];

  // Handshake status is a direct decode of the state register
  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = res_word;
  assign bus.rsp_c     = c_reg;
  assign bus.rsp_z     = z_reg;
  assign bus.rsp_n     = n_reg;
  assign bus.rsp_v     = v_reg;

  // ALU drive: active only in ISSUE; carry in is taken combinationally from
  // the ALU's registered carry for every byte after the first
  always_comb begin
    alu_rdy   = 1'b0;
    alu_op    = 4'b0000;
    alu_right = 1'b0;
    alu_ai    = 8'h00;
    alu_bi    = 8'h00;
    alu_ci    = 1'b0;
    alu_bcd   = 1'b0;
    if (state_reg == ISSUE) begin
      alu_rdy = 1'b1;
      case (op_reg)
        OP_ADD:  alu_op = 4'b0011;
        OP_SUB:  alu_op = 4'b0111;
        OP_CMP:  alu_op = 4'b0111;
        OP_OR:   alu_op = 4'b1100;
        OP_AND:  alu_op = 4'b1101;
        OP_EOR:  alu_op = 4'b1110;
        OP_ROL:  alu_op = 4'b1011;
        default: alu_op = 4'b1111;
      endcase
      alu_right = is_ror;
      alu_ai    = a_byte[issue_idx];
      alu_bi    = (is_ror || is_rol) ? 8'h00 : b_byte[issue_idx];
      alu_bcd   = is_arith & bcd_reg;
      if (k_reg != '0) begin
        alu_ci = alu_co;
      end else begin
        case (op_reg)
          OP_ADD, OP_SUB, OP_ROL, OP_ROR: alu_ci = ci_reg;
          OP_CMP:                         alu_ci = 1'b1;
          default:                        alu_ci = 1'b0;
        endcase
      end
    end
  end

  // Sequencer FSM: latch request, issue bytes, drain last result, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      ci_reg    <= 1'b0;
      bcd_reg   <= 1'b0;
      nz_reg    <= 1'b0;
      c_reg     <= 1'b0;
      z_reg     <= 1'b0;
      n_reg     <= 1'b0;
      v_reg     <= 1'b0;
      for (int i = 0; i < BYTES; i++) begin
        res_reg[i] <= 8'h00;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            op_reg    <= bus.req_op;
            a_reg     <= bus.req_a;
            b_reg     <= bus.req_b;
            ci_reg    <= bus.req_ci;
            bcd_reg   <= bus.req_bcd;
            nz_reg    <= 1'b0;
            k_reg     <= '0;
            for (int i = 0; i < BYTES; i++) begin
              res_reg[i] <= 8'h00;
            end
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (k_reg != '0) begin
            res_reg[prev_idx] <= alu_out;
            nz_reg            <= nz_reg | (|alu_out);
          end
          if (k_reg == K_LAST) begin
            state_reg <= DRAIN;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        DRAIN: begin
          res_reg[last_idx] <= alu_out;
          c_reg     <= is_logic ? 1'b0 : alu_co;
          v_reg     <= is_arith & alu_v;
          n_reg     <= final_msb;
          z_reg     <= ~(nz_reg | (|alu_out));
          state_reg <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural 8-bit ALU model on the ALU side, table of
// word-level vectors with hand-derived results, scoreboard queue of expected
// responses, plus hand sequences for back-pressure and mid-op reset.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int BYTES = 2;
  localparam int W     = 8 * BYTES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.BYTES(BYTES)) bus ();

  logic [3:0] alu_op;
  logic       alu_right;
  logic [7:0] alu_ai;
  logic [7:0] alu_bi;
  logic       alu_ci;
  logic       alu_bcd;
  logic       alu_rdy;
  logic [7:0] alu_out = 8'h00;
  logic       alu_co = 1'b0;
  logic       alu_v = 1'b0;

  alu_seq #(.BYTES(BYTES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_op   (alu_op),
    .alu_right(alu_right),
    .alu_ai   (alu_ai),
    .alu_bi   (alu_bi),
    .alu_ci   (alu_ci),
    .alu_bcd  (alu_bcd),
    .alu_rdy  (alu_rdy),
    .alu_out  (alu_out),
    .alu_co   (alu_co),
    .alu_v    (alu_v)
  );

  // Behavioural 8-bit ALU (binary mode only), outputs registered when rdy
  logic [7:0] m_lg;
  logic [7:0] m_bb;
  logic [8:0] m_sum;
  always @(posedge clk) begin
    if (alu_rdy) begin
      case (alu_op[1:0])
        2'b00:   m_lg = alu_ai | alu_bi;
        2'b01:   m_lg = alu_ai & alu_bi;
        2'b10:   m_lg = alu_ai ^ alu_bi;
        default: m_lg = alu_ai;
      endcase
      if (alu_right) m_lg = {alu_ci, alu_ai[7:1]};
      case (alu_op[3:2])
        2'b00:   m_bb = alu_bi;
        2'b01:   m_bb = ~alu_bi;
        2'b10:   m_bb = m_lg;
        default: m_bb = 8'h00;
      endcase
      m_sum = {1'b0, m_lg} + {1'b0, m_bb} + {8'h00, alu_ci};
      if (alu_right) begin
        alu_out <= m_lg;
        alu_co  <= alu_ai[0];
        alu_v   <= 1'b0;
      end else begin
        alu_out <= m_sum[7:0];
        alu_co  <= m_sum[8];
        alu_v   <= (m_lg[7] == m_bb[7]) && (m_sum[7] != m_lg[7]);
      end
    end
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         bcd;
    logic [W-1:0] d;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } rsp_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  rsp_t exp_q [$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] opmap(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b0011;
      3'd1:    return 4'b0111;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b1100;
      3'd4:    return 4'b1101;
      3'd5:    return 4'b1110;
      3'd6:    return 4'b1011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic ci_first(input logic [2:0] op, input logic ci);
    case (op)
      3'd0, 3'd1, 3'd6, 3'd7: return ci;
      3'd2:                   return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  task automatic present(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic bcd);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_ci    = ci;
    bus.req_bcd   = bcd;
    bus.req_valid = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
  endtask

  // Wait for a response, compare it with the scoreboard head, then take it
  task automatic collect();
    rsp_t e;
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.rsp_valid) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: rsp_valid=0 required 1");
      return;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: response data=%h with no expected entry", bus.rsp_data);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, e.d});
      chk("rsp_c", {31'd0, bus.rsp_c}, {31'd0, e.c});
      chk("rsp_z", {31'd0, bus.rsp_z}, {31'd0, e.z});
      chk("rsp_n", {31'd0, bus.rsp_n}, {31'd0, e.n});
      chk("rsp_v", {31'd0, bus.rsp_v}, {31'd0, e.v});
      $display("rsp data=%h c=%b z=%b n=%b v=%b (exp %h %b%b%b%b)", bus.rsp_data,
               bus.rsp_c, bus.rsp_z, bus.rsp_n, bus.rsp_v, e.d, e.c, e.z, e.n, e.v);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("idle_after_rsp", {31'd0, bus.req_ready}, 32'd1);
    chk("valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  // One full transaction with per-cycle checks of the ALU drive and latency
  task automatic run_vec(input vec_t v, input int idx);
    rsp_t e;
    int   bi;
    logic exp_ci;
    present(v.op, v.a, v.b, v.ci, v.bcd);
    wait_ready();
    tick();                       // handshake edge
    bus.req_valid = 1'b0;
    e.d = v.d; e.c = v.c; e.z = v.z; e.n = v.n; e.v = v.v;
    exp_q.push_back(e);
    for (int k = 0; k < BYTES; k++) begin
      bi = (v.op == 3'd7) ? (BYTES - 1 - k) : k;
      exp_ci = (k == 0) ? ci_first(v.op, v.ci) : alu_co;
      chk("issue_rdy", {31'd0, alu_rdy}, 32'd1);
      chk("issue_op", {28'd0, alu_op}, {28'd0, opmap(v.op)});
      chk("issue_right", {31'd0, alu_right}, {31'd0, v.op == 3'd7});
      chk("issue_ai", {24'd0, alu_ai}, {24'd0, v.a[bi*8 +: 8]});
      chk("issue_ci", {31'd0, alu_ci}, {31'd0, exp_ci});
      chk("issue_bcd", {31'd0, alu_bcd}, {31'd0, v.bcd && (v.op <= 3'd1)});
      chk("issue_req_ready", {31'd0, bus.req_ready}, 32'd0);
      if (idx == 0 && k == 1) chk("add_carry_cycle2", {31'd0, alu_ci}, 32'd1);
      tick();
    end
    chk("drain_rdy", {31'd0, alu_rdy}, 32'd0);
    chk("drain_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("latency_valid", {31'd0, bus.rsp_valid}, 32'd1);
    collect();
  endtask

  initial begin
    // op, a, b, ci, bcd, data, c, z, n, v
    vecs[0]  = '{3'd0, 16'h12FF, 16'h0001, 1'b0, 1'b0, 16'h1300, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'd2, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd7, 16'h0003, 16'h5555, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'd6, 16'h8001, 16'hAAAA, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd5, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{3'd1, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd4, 16'h00FF, 16'h00FF, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'd7, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'd2, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{3'd6, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ci    = 1'b0;
    bus.req_bcd   = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset state, held and after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("rst_flags", {28'd0, bus.rsp_c, bus.rsp_z, bus.rsp_n, bus.rsp_v}, 32'd0);
    chk("rst_alu_rdy", {31'd0, alu_rdy}, 32'd0);
    chk("rst_alu_drive", {8'd0, alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      $display("vec %0d op=%0d a=%h b=%h ci=%b", i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      run_vec(vecs[i], i);
    end

    // Back-pressure: first op ADD 0001+0001, second EOR 00FF^0F0F held on the bus
    present(3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_ready();
    tick();
    exp_q.push_back('{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});
    present(3'd5, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    for (int n = 0; n < 50 && !bus.rsp_valid; n++) tick();
    for (int n = 0; n < 5; n++) begin
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_data", {16'd0, bus.rsp_data}, 32'h0002);
      chk("bp_flags", {28'd0, bus.rsp_c, bus.rsp_z, bus.rsp_n, bus.rsp_v}, 32'd0);
      tick();
    end
    $display("backpressure: releasing rsp_ready");
    collect();
    tick();                       // second request accepted here
    bus.req_valid = 1'b0;
    exp_q.push_back('{16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("bp_second_accepted", {31'd0, bus.req_ready}, 32'd0);
    chk("bp_second_issue", {31'd0, alu_rdy}, 32'd1);
    collect();

    // Reset during ISSUE
    present(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    chk("mid_rst_in_issue", {31'd0, alu_rdy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_rdy", {31'd0, alu_rdy}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_alu_drive", {8'd0, alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd}, 32'd0);
    chk("mid_rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("no_rsp_after_rst", {31'd0, bus.rsp_valid}, 32'd0);
    end
    $display("reset abort: no response observed window done");

    // Normal operation resumes after the abort
    run_vec(vecs[0], 0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-byte operation sequencer for the 8-bit ALU. It accepts one `BYTES`-wide operation per request handshake and issues it to the ALU one byte per cycle, chaining carry through the ALU's registered `CO`. It collects the result bytes, forms whole-word flags and returns them on a response handshake. It sits between the microcode or DMA issue logic and the single shared ALU instance, and owns that ALU's `op`, `right`, `AI`, `BI`, `CI`, `BCD` and `RDY` inputs.

## Interface
- `BYTES`, default 2: operand width in bytes, 1..8; word width `W = 8*BYTES`.
- `clk` in 1: clock, all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 3: operation code. 000 ADD, 001 SUB, 010 CMP, 011 OR, 100 AND, 101 EOR, 110 ROL, 111 ROR.
- `req_a`, `req_b` in W: operands. `req_b` is ignored for ROL and ROR.
- `req_ci` in 1: carry or borrow-not in; the shift-in bit for ROL and ROR.
- `req_bcd` in 1: BCD carry mode, honoured for ADD and SUB only.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_data` out W: result word.
- `rsp_c`, `rsp_z`, `rsp_n`, `rsp_v` out 1 each: word flags.
- `alu_op` out 4, `alu_right` out 1, `alu_ai` out 8, `alu_bi` out 8, `alu_ci` out 1, `alu_bcd` out 1, `alu_rdy` out 1: drive the ALU.
- `alu_out` in 8, `alu_co` in 1, `alu_v` in 1: ALU results, registered by the ALU and valid the cycle after an `alu_rdy=1` cycle.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP. A byte counter `k` runs 0..BYTES-1.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid & req_ready`: latch op, operands, `ci` and `bcd`; clear the result register and Z accumulator; set `k=0`; go to ISSUE.
- **ISSUE**
  - `alu_rdy=1`.
  - Byte order:
    - ROR: byte `BYTES-1-k`, MSB byte first.
    - All other ops: byte `k`, LSB byte first.
  - `alu_op` mapping:
    - ADD 0011, SUB 0111, CMP 0111, ROL 1011.
    - OR 1100, AND 1101, EOR 1110, ROR 1111.
  - `alu_right=1` only for ROR.
  - `alu_bcd = latched bcd` for ADD/SUB, else 0.
  - `alu_ci`:
    - `k=0`: ADD/SUB/ROL/ROR use latched `ci`; CMP uses 1; logic ops use 0.
    - `k>0`: `alu_ci = alu_co` (previous byte's carry) for every op.
  - When `k>0`, capture `alu_out` from the previous byte into its result slot and OR it into the zero accumulator.
  - `k` increments each cycle. After `k=BYTES-1`, go to DRAIN.
- **DRAIN**
  - `alu_rdy=0`.
  - Capture the last byte.
  - Flags:
    - `rsp_c = alu_co` for ADD/SUB/CMP/ROL/ROR, 0 for logic ops.
    - `rsp_v = alu_v` for ADD/SUB, 0 otherwise.
    - `rsp_n = rsp_data[W-1]`.
    - `rsp_z = 1` iff all W result bits are 0.
  - Go to RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_data` and flags are stable.
  - On `rsp_ready`, go to IDLE.
- CMP returns the difference `A-B` in `rsp_data` with C, Z and N set; V is 0.
- `alu_rdy=0` outside ISSUE, so the ALU's registered outputs hold.
- ALU data inputs are don't-care when `alu_rdy=0`. They are driven 0 to ease waveform checks.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, all flags 0, `alu_rdy=0`, all `alu_*` outputs 0.
- Latency: handshake in cycle 0; ISSUE in cycles 1..BYTES; DRAIN in cycle BYTES+1; `rsp_valid` first high in cycle BYTES+2. For BYTES=2, `rsp_valid` is first high in cycle 4.
- Throughput: at most one op per BYTES+3 cycles. `req_ready` is 0 from the cycle after the handshake until the cycle after the response handshake.
- Back-pressure: while `rsp_ready=0`, RESP holds indefinitely and `rsp_*` must not change.
- No request is accepted in the same cycle as the response handshake. IDLE is re-entered first.
- Carry chaining is combinational from the registered `alu_co` to `alu_ci` in the same cycle. No bubble between bytes.
- Reset mid-operation: state and outputs return to reset values asynchronously. The aborted op produces no response after `rst_n` rises.
- BYTES=1: ISSUE lasts 1 cycle and no capture happens in ISSUE.

## Test plan
- ADD, BYTES=2: `a=0x12FF`, `b=0x0001`, `ci=0` → `rsp_data=0x1300`, C=0, Z=0, N=0, V=0. `rsp_valid` rises exactly 4 cycles after the handshake. The carry from byte 0 appears on `alu_ci` in cycle 2.
- SUB: `a=0x8000`, `b=0x0001`, `ci=1` → `0x7FFF`, C=1, V=1, N=0, Z=0. `alu_op=0111` in both ISSUE cycles.
- CMP: `a=b=0x1234` → data `0x0000`, Z=1, C=1, N=0, V=0. `alu_ci=1` at k=0 regardless of `req_ci=0`.
- ROR `a=0x0003`, `ci=1` → `0x8001`, C=1, N=1, with the MSB byte issued first and `alu_right=1`. ROL `a=0x8001`, `ci=0` → `0x0002`, C=1.
- Back-pressure: `rsp_ready=0` for 5 cycles with `req_valid` held high → `req_ready=0` and `rsp_*` stable throughout. After `rsp_ready=1`, IDLE is reached next cycle and the second request is accepted.
- Reset during ISSUE, `rst_n=0` for 1 cycle → immediate reset values, `alu_rdy=0`, and no `rsp_valid` for 10 cycles afterwards.
